// File: rtl/controlador_medida_pkg.sv
// Shared definitions for the periodic distance-measurement sequencer:
// state codes, 50 MHz default timing and small width helpers.
package controlador_medida_pkg;

    typedef enum logic [2:0] {
        ST_INICIAL  = 3'd0,
        ST_PREPARA  = 3'd1,
        ST_TRIGGER  = 3'd2,
        ST_ESPERA   = 3'd3,
        ST_REGISTRA = 3'd4,
        ST_TIMEOUT  = 3'd5,
        ST_AGUARDA  = 3'd6,
        ST_FALHA    = 3'd7
    } estado_t;

    localparam int PERIODO_50M       = 5_000_000;
    localparam int LARGURA_50M       = 500;
    localparam int TIMEOUT_50M       = 1_500_000;
    localparam int MAX_FALHAS_PADRAO = 3;

    // Counter width for a modulus, never narrower than one bit.
    function automatic int bits_para(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int maximo(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/controlador_medida_periodica_contador_m.sv
// Modulo-M up counter with asynchronous clear, synchronous clear and count enable.
module contador_m #(
    parameter int M = 100,
    parameter int N = 7
) (
    input  logic         i_clock,
    input  logic         i_zera_as,
    input  logic         i_zera_s,
    input  logic         i_conta,
    output logic [N-1:0] o_q
);

    localparam logic [N-1:0] C_ULTIMO = N'(M - 1);

    logic [N-1:0] r_q;

    always_ff @(posedge i_clock or posedge i_zera_as) begin
        if (i_zera_as) begin
            r_q <= '0;
        end else if (i_zera_s) begin
            r_q <= '0;
        end else if (i_conta) begin
            r_q <= (r_q == C_ULTIMO) ? '0 : r_q + N'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/controlador_medida_periodica.sv
// Periodic trigger / wait-for-pronto sequencer with timeout counting and a
// latched error state after too many consecutive missed measurements.
module controlador_medida_periodica
    import controlador_medida_pkg::*;
#(
    parameter int PERIODO    = PERIODO_50M,
    parameter int LARGURA    = LARGURA_50M,
    parameter int TIMEOUT    = TIMEOUT_50M,
    parameter int MAX_FALHAS = MAX_FALHAS_PADRAO
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            ligar,
    input  logic                            pronto,
    output logic                            trigger,
    output logic                            registra,
    output logic                            timeout,
    output logic                            ocupado,
    output logic                            erro,
    output logic [$clog2(MAX_FALHAS+1)-1:0] falhas,
    output logic [2:0]                      db_estado
);

    localparam int W_PER = bits_para(PERIODO);
    localparam int M_INT = maximo(LARGURA, TIMEOUT);
    localparam int W_INT = bits_para(M_INT);
    localparam int W_F   = $clog2(MAX_FALHAS + 1);

    localparam logic [W_PER-1:0] C_FIM_PERIODO = W_PER'(PERIODO - 1);
    localparam logic [W_INT-1:0] C_FIM_LARGURA = W_INT'(LARGURA - 1);
    localparam logic [W_INT-1:0] C_FIM_TIMEOUT = W_INT'(TIMEOUT - 1);
    localparam logic [W_F-1:0]   C_MAX_FALHAS  = W_F'(MAX_FALHAS);

    // The schedule must reach AGUARDA before the period counter wraps.
    if (LARGURA + TIMEOUT + 2 >= PERIODO) begin : g_parametros_invalidos
        $error("controlador_medida_periodica: LARGURA + TIMEOUT + 2 must be < PERIODO");
    end

    estado_t          r_estado;
    estado_t          w_proximo;
    logic [W_F-1:0]   r_falhas;
    logic [W_F-1:0]   w_falhas_inc;
    logic [W_PER-1:0] w_cont_per;
    logic [W_INT-1:0] w_cont_int;
    logic             w_zera_as;
    logic             w_zera_per;
    logic             w_conta_per;
    logic             w_zera_int;
    logic             w_conta_int;
    logic             w_fim_periodo;
    logic             w_fim_largura;
    logic             w_fim_timeout;

    assign w_zera_as     = ~reset_n;
    assign w_fim_periodo = (w_cont_per == C_FIM_PERIODO);
    assign w_fim_largura = (w_cont_int == C_FIM_LARGURA);
    assign w_fim_timeout = (w_cont_int == C_FIM_TIMEOUT);
    assign w_falhas_inc  = (r_falhas == C_MAX_FALHAS) ? r_falhas : r_falhas + W_F'(1);

    contador_m #(
        .M (PERIODO),
        .N (W_PER)
    ) u_contador_periodo (
        .i_clock   (clock),
        .i_zera_as (w_zera_as),
        .i_zera_s  (w_zera_per),
        .i_conta   (w_conta_per),
        .o_q       (w_cont_per)
    );

    contador_m #(
        .M (M_INT),
        .N (W_INT)
    ) u_contador_intervalo (
        .i_clock   (clock),
        .i_zera_as (w_zera_as),
        .i_zera_s  (w_zera_int),
        .i_conta   (w_conta_int),
        .o_q       (w_cont_int)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= ST_INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_falhas <= '0;
        end else if (r_estado == ST_PREPARA || r_estado == ST_REGISTRA) begin
            r_falhas <= '0;
        end else if (r_estado == ST_TIMEOUT) begin
            r_falhas <= w_falhas_inc;
        end
    end

    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            ST_INICIAL:  if (ligar) w_proximo = ST_PREPARA;
            ST_PREPARA:  w_proximo = ST_TRIGGER;
            ST_TRIGGER:  if (w_fim_largura) w_proximo = ST_ESPERA;
            // pronto takes priority over a coincident final timeout count
            ST_ESPERA: begin
                if (pronto) begin
                    w_proximo = ST_REGISTRA;
                end else if (w_fim_timeout) begin
                    w_proximo = ST_TIMEOUT;
                end
            end
            ST_REGISTRA: w_proximo = ST_AGUARDA;
            ST_TIMEOUT:  w_proximo = (w_falhas_inc == C_MAX_FALHAS) ? ST_FALHA : ST_AGUARDA;
            ST_AGUARDA: begin
                if (!ligar) begin
                    w_proximo = ST_INICIAL;
                end else if (w_fim_periodo) begin
                    w_proximo = ST_TRIGGER;
                end
            end
            ST_FALHA:    if (!ligar) w_proximo = ST_INICIAL;
            default:     w_proximo = ST_INICIAL;
        endcase
    end

    // The period counter runs through the whole measurement so triggers stay
    // on a fixed grid; the interval counter is held at zero outside its phases.
    always_comb begin
        w_conta_per = 1'b0;
        w_zera_per  = 1'b0;
        w_conta_int = 1'b0;
        w_zera_int  = 1'b0;
        case (r_estado)
            ST_INICIAL, ST_PREPARA: begin
                w_zera_per = 1'b1;
                w_zera_int = 1'b1;
            end
            ST_TRIGGER: begin
                w_conta_per = 1'b1;
                w_conta_int = 1'b1;
                w_zera_int  = w_fim_largura;
            end
            ST_ESPERA: begin
                w_conta_per = 1'b1;
                w_conta_int = 1'b1;
            end
            ST_REGISTRA, ST_TIMEOUT, ST_AGUARDA: begin
                w_conta_per = 1'b1;
                w_zera_int  = 1'b1;
            end
            ST_FALHA: begin
                w_zera_int = 1'b1;
            end
            default: begin
                w_zera_per = 1'b1;
                w_zera_int = 1'b1;
            end
        endcase
    end

    always_comb begin
        trigger   = (r_estado == ST_TRIGGER);
        registra  = (r_estado == ST_REGISTRA);
        timeout   = (r_estado == ST_TIMEOUT);
        ocupado   = (r_estado != ST_INICIAL) && (r_estado != ST_FALHA);
        erro      = (r_estado == ST_FALHA);
        falhas    = r_falhas;
        db_estado = r_estado;
    end

endmodule

// File: tb/tb_controlador_medida_periodica.sv
// Directed bench for controlador_medida_periodica with PERIODO=100, LARGURA=5,
// TIMEOUT=20, MAX_FALHAS=3; expected values are hand-derived from the timing rules.
module tb_controlador_medida_periodica;

    localparam int P  = 100;
    localparam int L  = 5;
    localparam int T  = 20;
    localparam int MF = 3;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       ligar   = 1'b0;
    logic       pronto  = 1'b0;
    logic       trigger;
    logic       registra;
    logic       timeout;
    logic       ocupado;
    logic       erro;
    logic [1:0] falhas;
    logic [2:0] db_estado;

    int   n_checks  = 0;
    int   n_erros   = 0;
    int   ciclo     = 0;
    int   t_subida  = 0;
    int   t_ant     = 0;
    logic trig_ant  = 1'b0;

    controlador_medida_periodica #(
        .PERIODO    (P),
        .LARGURA    (L),
        .TIMEOUT    (T),
        .MAX_FALHAS (MF)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ligar     (ligar),
        .pronto    (pronto),
        .trigger   (trigger),
        .registra  (registra),
        .timeout   (timeout),
        .ocupado   (ocupado),
        .erro      (erro),
        .falhas    (falhas),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Trigger rising-edge timestamps, in clock cycles.
    always @(posedge clock) begin
        #1;
        ciclo = ciclo + 1;
        if (trigger === 1'b1 && trig_ant !== 1'b1) begin
            t_ant    = t_subida;
            t_subida = ciclo;
        end
        trig_ant = trigger;
    end

    task automatic verifica(input string tag, input int obtido, input int esperado);
        n_checks = n_checks + 1;
        if (obtido !== esperado) begin
            n_erros = n_erros + 1;
            $display("FAIL %s: obtido=%0d esperado=%0d", tag, obtido, esperado);
        end
    endtask

    task automatic passo(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic aguarda_estado(input string tag, input logic [2:0] e, input int limite, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n = n + 1;
        end while (db_estado !== e && n < limite);
        verifica(tag, int'(db_estado), int'(e));
    endtask

    initial begin
        int n;
        int n_trig;

        // Reset state
        passo(2);
        verifica("rst_estado", db_estado, 0);
        verifica("rst_trigger", trigger, 0);
        verifica("rst_registra", registra, 0);
        verifica("rst_timeout", timeout, 0);
        verifica("rst_ocupado", ocupado, 0);
        verifica("rst_erro", erro, 0);
        verifica("rst_falhas", falhas, 0);

        // Start: one PREPARA cycle, five trigger cycles, then ESPERA
        reset_n = 1'b1;
        passo(1);
        ligar = 1'b1;
        passo(1);
        verifica("prepara_estado", db_estado, 1);
        verifica("prepara_ocupado", ocupado, 1);
        n_trig = 0;
        repeat (L) begin
            passo(1);
            n_trig = n_trig + int'(trigger);
        end
        verifica("largura_trigger", n_trig, L);
        passo(1);
        verifica("espera_inicio", db_estado, 3);
        verifica("espera_trigger_baixo", trigger, 0);

        // pronto on the 7th ESPERA cycle
        passo(6);
        pronto = 1'b1;
        passo(1);
        pronto = 1'b0;
        verifica("registra_alto", registra, 1);
        verifica("registra_estado", db_estado, 4);
        passo(1);
        verifica("registra_um_ciclo", registra, 0);
        verifica("registra_falhas", falhas, 0);
        verifica("aguarda_estado", db_estado, 6);
        aguarda_estado("trig2_estado", 3'd2, 150, n);
        verifica("grade_periodo_1", t_subida - t_ant, P);

        // No pronto: timeout after exactly T ESPERA cycles
        aguarda_estado("espera2_estado", 3'd3, 10, n);
        aguarda_estado("timeout1_estado", 3'd5, 30, n);
        verifica("espera_ciclos_timeout", n, T);
        verifica("timeout1_alto", timeout, 1);
        passo(1);
        verifica("timeout1_um_ciclo", timeout, 0);
        verifica("timeout1_falhas", falhas, 1);
        aguarda_estado("trig3_estado", 3'd2, 150, n);
        verifica("grade_periodo_2", t_subida - t_ant, P);

        // Second and third consecutive timeouts -> FALHA
        aguarda_estado("timeout2_estado", 3'd5, 150, n);
        passo(1);
        verifica("timeout2_falhas", falhas, 2);
        verifica("timeout2_aguarda", db_estado, 6);
        aguarda_estado("timeout3_estado", 3'd5, 150, n);
        passo(1);
        verifica("falha_estado", db_estado, 7);
        verifica("falha_erro", erro, 1);
        verifica("falha_falhas", falhas, MF);
        verifica("falha_ocupado", ocupado, 0);
        n_trig = 0;
        repeat (150) begin
            passo(1);
            n_trig = n_trig + int'(trigger);
        end
        verifica("falha_sem_trigger", n_trig, 0);
        verifica("falha_retida", db_estado, 7);
        ligar = 1'b0;
        passo(1);
        verifica("falha_sai_estado", db_estado, 0);
        verifica("falha_sai_erro", erro, 0);
        verifica("inicial_falhas_retidas", falhas, MF);

        // pronto during TRIGGER is ignored; pronto on the final count wins
        ligar = 1'b1;
        aguarda_estado("trig4_estado", 3'd2, 5, n);
        verifica("prepara_zera_falhas", falhas, 0);
        pronto = 1'b1;
        aguarda_estado("pronto_ignorado", 3'd3, 10, n);
        pronto = 1'b0;
        verifica("pronto_ignorado_largura", n, L);
        passo(T - 1);
        verifica("espera_ciclo20", db_estado, 3);
        pronto = 1'b1;
        passo(1);
        pronto = 1'b0;
        verifica("pronto_final_registra", registra, 1);
        verifica("pronto_final_timeout", timeout, 0);
        verifica("pronto_final_estado", db_estado, 4);

        // ligar dropped mid-ESPERA: measurement completes, exit from AGUARDA
        aguarda_estado("espera5_estado", 3'd3, 150, n);
        ligar = 1'b0;
        passo(3);
        verifica("desliga_continua", db_estado, 3);
        pronto = 1'b1;
        passo(1);
        pronto = 1'b0;
        verifica("desliga_registra", db_estado, 4);
        passo(1);
        verifica("desliga_aguarda", db_estado, 6);
        passo(1);
        verifica("desliga_inicial", db_estado, 0);
        verifica("desliga_ocupado", ocupado, 0);

        // Asynchronous reset mid-ESPERA with a nonzero falhas count
        ligar = 1'b1;
        aguarda_estado("timeout6_estado", 3'd5, 50, n);
        passo(1);
        verifica("timeout6_falhas", falhas, 1);
        aguarda_estado("espera7_estado", 3'd3, 150, n);
        passo(2);
        #1 reset_n = 1'b0;
        #1;
        verifica("rst_async_estado", db_estado, 0);
        verifica("rst_async_ocupado", ocupado, 0);
        verifica("rst_async_falhas", falhas, 0);
        verifica("rst_async_trigger", trigger, 0);
        verifica("rst_async_erro", erro, 0);
        passo(2);
        verifica("rst_mantido_estado", db_estado, 0);
        reset_n = 1'b1;
        passo(2);

        $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
        $finish;
    end

endmodule

// File: doc/controlador_medida_periodica.md
# controlador_medida_periodica

Sequencer for the drone's periodic distance-measurement path. It paces the sensor with a fixed-period trigger pulse and waits for the sensor's `pronto` with a timeout. It emits a one-cycle `registra` strobe so downstream registers latch the result. It counts consecutive timeouts and enters a latched error state when the limit is reached. It sits between the top-level control (`ligar`) and the sensor interface, and drives two modulo counters for all of its timing.

## Interface
- `PERIODO`, default 5_000_000: clocks between successive first trigger cycles (100 ms at 50 MHz).
- `LARGURA`, default 500: trigger pulse width in clocks (10 us).
- `TIMEOUT`, default 1_500_000: maximum clocks spent waiting for `pronto`.
- `MAX_FALHAS`, default 3: consecutive timeouts that force the error state.
- Parameter constraint: `LARGURA + TIMEOUT + 2 < PERIODO`, checked at elaboration.
- `clock`  in  1: single system clock, rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `ligar`  in  1: level enable for periodic measurement.
- `pronto`  in  1: sensor done, synchronous, sampled only in ESPERA.
- `trigger`  out  1: sensor trigger pulse.
- `registra`  out  1: one-cycle strobe to latch the measurement.
- `timeout`  out  1: one-cycle strobe on a missed `pronto`.
- `ocupado`  out  1: high when the state is not INICIAL and not FALHA.
- `erro`  out  1: high in FALHA.
- `falhas`  out  `$clog2(MAX_FALHAS+1)`: consecutive-timeout count.
- `db_estado`  out  3: state code, for debug.

## Operation
- States and codes: INICIAL 0, PREPARA 1, TRIGGER 2, ESPERA 3, REGISTRA 4, TIMEOUT 5, AGUARDA 6, FALHA 7. The FSM is Moore; outputs decode from the state register.
- INICIAL: `ligar`=1 → PREPARA.
- PREPARA: lasts 1 cycle. Synchronously zeroes both counters and `falhas`. → TRIGGER.
- TRIGGER: `trigger`=1. When the interval count reaches `LARGURA-1` → ESPERA, and the interval counter is zeroed.
- ESPERA: `pronto`=1 → REGISTRA. Else, when the interval count reaches `TIMEOUT-1` → TIMEOUT. If `pronto` and the final count occur in the same cycle, `pronto` wins.
- REGISTRA: `registra`=1 and `falhas` clears to 0. → AGUARDA.
- TIMEOUT: `timeout`=1 and `falhas` increments (saturating). If the new value equals `MAX_FALHAS` → FALHA; else → AGUARDA.
- AGUARDA: `ligar`=0 → INICIAL. Otherwise, when the period count reaches `PERIODO-1` → TRIGGER. The period counter wraps to 0 and the interval counter is zeroed.
- FALHA: `erro`=1 and `trigger`=0. `ligar`=0 → INICIAL. `falhas` holds its value until PREPARA.
- Period counter: counts every cycle in TRIGGER, ESPERA, REGISTRA, TIMEOUT and AGUARDA. It is zeroed in PREPARA and INICIAL.
- `pronto` is ignored outside ESPERA. `ligar` falling mid-measurement does not abort the measurement; the block returns to INICIAL from AGUARDA.
- Interval counter: one counter is shared by the pulse-width and timeout phases. Its modulus is `max(LARGURA, TIMEOUT)`, and the block compares the count value against `LARGURA-1` and `TIMEOUT-1` directly rather than using the counter's end flag.

## Timing
- Reset (`reset_n`=0, any state, asynchronous): state returns to INICIAL, and all outputs and counters return to 0 immediately.
- `ligar` seen high in INICIAL at edge k: PREPARA during k+1, first `trigger` cycle at k+2.
- `trigger` stays high for exactly `LARGURA` cycles. ESPERA begins on the next cycle.
- `pronto` sampled at ESPERA cycle j: `registra` is high during the following cycle.
- No `pronto`: `timeout` is high during the cycle after the `TIMEOUT`th ESPERA cycle.
- Rising edges of `trigger` are exactly `PERIODO` cycles apart while `ligar`=1 and the block is not in FALHA.

## Structure
- Shared package `controlador_medida_pkg` holds:
  - the state code constants (0–7, 3 bits);
  - the default 50 MHz timing constants.
- Counter widths are derived locally with `$clog2`.
- The counters are two instances of the codebase's `contador_m` (period and interval). Synchronous clear and count enable come from the FSM; the asynchronous clear input is driven by `~reset_n`.

## Test plan
All scenarios use `PERIODO`=100, `LARGURA`=5, `TIMEOUT`=20, `MAX_FALHAS`=3.
- Reset, then `ligar`=1 → one PREPARA cycle (`db_estado`=1), `trigger` high for 5 cycles, then `db_estado`=3.
- `pronto` pulsed on the 7th ESPERA cycle → `registra` high for 1 cycle, `falhas`=0, and the next `trigger` rising edge comes exactly 100 cycles after the previous one.
- No `pronto` → `timeout` high for 1 cycle after 20 ESPERA cycles, `falhas`=1, and the next trigger stays on the 100-cycle grid.
- Three consecutive timeouts → `erro`=1, `db_estado`=7, `falhas`=3 and no further triggers. Then `ligar`=0 → `db_estado`=0 and `erro`=0.
- `pronto` asserted on ESPERA cycle 20, coinciding with the final count → `registra` high and `timeout` stays 0. `pronto` asserted during TRIGGER is ignored.
- `ligar` dropped mid-ESPERA → the measurement completes and the block returns to INICIAL from AGUARDA. `reset_n` low mid-ESPERA → all outputs 0 and `db_estado`=0 without waiting for a clock edge.
